or1k_wb_arbiter: RTL



---
 rtl/or1k_wb_arbiter_pkg.sv | 9 +
 rtl/or1k_wb_arb_watchdog.sv | 22 ++
 rtl/or1k_wb_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/or1k_wb_arbiter_pkg.sv
// or1k_wb_arbiter_pkg: arbiter states, one-hot grant encodings and Wishbone cycle type codes
package or1k_wb_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, GNT_I = 2'b01, GNT_D = 2'b10, TOERR = 2'b11} arb_state_e;
  localparam logic [1:0] GRANT_I = 2'b01;
  localparam logic [1:0] GRANT_D = 2'b10;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB = 3'b111;
endpackage

// File: rtl/or1k_wb_arb_watchdog.sv
// or1k_wb_arb_watchdog: counts unanswered strobe cycles (clk, rst, active_i, stb_i, resp_i in; expire_o out)
module or1k_wb_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic stb_i,
  input  logic resp_i,
  output logic expire_o
);
  localparam logic [TIMEOUT_WIDTH-1:0] limit = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic clr;
  always_comb begin
    clr = !active_i || !stb_i || resp_i;
    cnt_d = clr ? '0 : (cnt_q == limit ? cnt_q : cnt_q + 1'b1);
    expire_o = (TIMEOUT_CYCLES != 0) && !clr && cnt_d == limit;
  end
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/or1k_wb_arbiter.sv
// or1k_wb_arbiter: shares one Wishbone bus between iwb/dwb masters; wbm_* bus side, grant_o owner, timeout_o watchdog pulse
module or1k_wb_arbiter
  import or1k_wb_arbiter_pkg::*;
#(
  parameter string ARB_POLICY = "ROUND_ROBIN",
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iwb_adr_i,
  input  logic [31:0] iwb_dat_i,
  input  logic [3:0]  iwb_sel_i,
  input  logic        iwb_we_i,
  input  logic [2:0]  iwb_cti_i,
  input  logic [1:0]  iwb_bte_i,
  input  logic        iwb_cyc_i,
  input  logic        iwb_stb_i,
  output logic        iwb_ack_o,
  output logic        iwb_err_o,
  output logic        iwb_rty_o,
  output logic [31:0] iwb_dat_o,
  input  logic [31:0] dwb_adr_i,
  input  logic [31:0] dwb_dat_i,
  input  logic [3:0]  dwb_sel_i,
  input  logic        dwb_we_i,
  input  logic [2:0]  dwb_cti_i,
  input  logic [1:0]  dwb_bte_i,
  input  logic        dwb_cyc_i,
  input  logic        dwb_stb_i,
  output logic        dwb_ack_o,
  output logic        dwb_err_o,
  output logic        dwb_rty_o,
  output logic [31:0] dwb_dat_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i,
  input  logic [31:0] wbm_dat_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);
  localparam bit fixed_data = (ARB_POLICY == "FIXED_DATA");
  arb_state_e state_q, state_d;
  logic [1:0] last_grant_q, last_grant_d;
  logic own_i, own_d, to_err, owner_cyc, owner_stb, pick_d, expire;
  assign own_i = state_q == GNT_I;
  assign own_d = state_q == GNT_D;
  assign to_err = state_q == TOERR;
  assign owner_cyc = own_i ? iwb_cyc_i : dwb_cyc_i;
  assign owner_stb = own_i ? iwb_stb_i : dwb_stb_i;
  assign pick_d = dwb_cyc_i && (!iwb_cyc_i || fixed_data || last_grant_q == GRANT_I);
  always_comb begin
    state_d = state_q;
    last_grant_d = last_grant_q;
    if (state_q == IDLE) begin
      if (iwb_cyc_i || dwb_cyc_i) begin
        state_d = pick_d ? GNT_D : GNT_I;
        last_grant_d = pick_d ? GRANT_D : GRANT_I;
      end
    end else if (to_err || !owner_cyc) state_d = IDLE;
    else if (expire) state_d = TOERR;
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
    last_grant_q <= rst ? GRANT_I : last_grant_d;
  end
  or1k_wb_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TIMEOUT_WIDTH(TIMEOUT_WIDTH)) u_wdog (
    .clk(clk),
    .rst(rst),
    .active_i(own_i || own_d),
    .stb_i(owner_stb),
    .resp_i(wbm_ack_i || wbm_err_i || wbm_rty_i),
    .expire_o(expire)
  );
  assign wbm_adr_o = own_i ? iwb_adr_i : own_d ? dwb_adr_i : '0;
  assign wbm_dat_o = own_i ? iwb_dat_i : own_d ? dwb_dat_i : '0;
  assign wbm_sel_o = own_i ? iwb_sel_i : own_d ? dwb_sel_i : '0;
  assign wbm_we_o  = own_i ? iwb_we_i  : own_d && dwb_we_i;
  assign wbm_cti_o = own_i ? iwb_cti_i : own_d ? dwb_cti_i : '0;
  assign wbm_bte_o = own_i ? iwb_bte_i : own_d ? dwb_bte_i : '0;
  assign wbm_cyc_o = own_i ? iwb_cyc_i : own_d && dwb_cyc_i;
  assign wbm_stb_o = own_i ? iwb_stb_i : own_d && dwb_stb_i;
  assign iwb_ack_o = own_i && wbm_ack_i;
  assign iwb_rty_o = own_i && wbm_rty_i;
  assign iwb_err_o = (own_i && wbm_err_i) || (to_err && last_grant_q == GRANT_I);
  assign dwb_ack_o = own_d && wbm_ack_i;
  assign dwb_rty_o = own_d && wbm_rty_i;
  assign dwb_err_o = (own_d && wbm_err_i) || (to_err && last_grant_q == GRANT_D);
  assign iwb_dat_o = wbm_dat_i;
  assign dwb_dat_o = wbm_dat_i;
  assign grant_o = own_i ? GRANT_I : own_d ? GRANT_D : 2'b00;
  assign timeout_o = to_err;
endmodule
